// File: rtl/fetch_pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl_pkg
// Shared types and constants for the fetch-stage PC sequencer.
//   addr_t / word_t   : 32-bit address and instruction word types
//   DEFAULT_RESET_PC  : first fetch address after reset
//   fetch_state_t     : sequencer states
//   is_misaligned()   : true when an address is not word aligned
// -----------------------------------------------------------------------------
package fetch_pc_ctrl_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam addr_t DEFAULT_RESET_PC = 32'hBFC0_0000;
    localparam addr_t PC_STEP          = 32'd4;

    typedef enum logic [2:0] {
        S_RST,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } fetch_state_t;

    function automatic logic is_misaligned(input addr_t a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
// Fetch-stage PC sequencer. Owns the fetch PC, issues one instruction-bus
// request at a time, hands each fetched word to Decode over valid/ready and
// squashes wrong-path fetches when Execute redirects.
//
// Ports
//   clk, reset                 core clock; asynchronous active-high reset
//   ireq_valid/addr/ready      instruction request (addr stable until accepted)
//   iresp_valid/data           one response per accepted request
//   if_valid/pc/instr/ready    fetched word to Decode
//   redirect_valid/pc          one-cycle redirect pulse from Execute
//   if_adel                    fetch address error flag
//
// Build option
//   FETCH_ADEL_CHECK_EN : a misaligned PC is not fetched; a nop with if_adel=1
//                         is handed to Decode instead. Undefined: if_adel=0.
// -----------------------------------------------------------------------------
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic  clk,
    input  logic  reset,
    output logic  ireq_valid,
    output addr_t ireq_addr,
    input  logic  ireq_ready,
    input  logic  iresp_valid,
    input  word_t iresp_data,
    output logic  if_valid,
    output addr_t if_pc,
    output word_t if_instr,
    input  logic  if_ready,
    input  logic  redirect_valid,
    input  addr_t redirect_pc,
    output logic  if_adel
);

    fetch_state_t state_q;
    addr_t        pc_q, pc_d;
    addr_t        pend_q;        // redirect target waiting for the squashed response
    logic         redir_q;       // redirect seen while the request was unaccepted
    logic         ireq_valid_q;
    logic         if_valid_q;
    addr_t        if_pc_q;
    word_t        if_instr_q;
    logic         if_adel_q;

    logic         enter_req;     // this cycle ends with a new fetch at pc_d
    logic         adel_entry;    // ... but pc_d is misaligned and must not be fetched

    // Every path that starts a new fetch, and the PC it fetches. A redirect
    // always takes priority over the sequential +4.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        enter_req = 1'b0;
        pc_d      = pc_q;
        case (state_q)
            S_RST: enter_req = 1'b1;
            S_WAIT: begin
                // Redirect racing the response: the word is wrong-path, and the
                // bus is already idle, so go straight to the target.
                if (iresp_valid && redirect_valid) begin
                    enter_req = 1'b1;
                    pc_d      = redirect_pc;
                end
            end
            S_DRAIN: begin
                if (iresp_valid) begin
                    enter_req = 1'b1;
                    pc_d      = redirect_valid ? redirect_pc : pend_q;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    enter_req = 1'b1;
                    pc_d      = redirect_pc;
                end else if (if_ready) begin
                    enter_req = 1'b1;
                    pc_d      = pc_q + PC_STEP;   // wraps mod 2^32
                end
            end
            default: ;
        endcase
    end

`ifdef FETCH_ADEL_CHECK_EN
    assign adel_entry = enter_req && is_misaligned(pc_d);
`else
    assign adel_entry = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RST;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            redir_q      <= 1'b0;
            ireq_valid_q <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= '0;
            if_adel_q    <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (enter_req) begin
                redir_q <= 1'b0;
                if (adel_entry) begin
                    // Skip the bus: hand Decode a nop flagged as an address error.
                    state_q      <= S_HOLD;
                    ireq_valid_q <= 1'b0;
                    if_valid_q   <= 1'b1;
                    if_pc_q      <= pc_d;
                    if_instr_q   <= '0;
                    if_adel_q    <= 1'b1;
                end else begin
                    state_q      <= S_REQ;
                    ireq_valid_q <= 1'b1;
                    if_valid_q   <= 1'b0;
                    if_adel_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_REQ: begin
                        // The address must not move until accepted, so a
                        // redirect here is only remembered.
                        if (redirect_valid) pend_q <= redirect_pc;
                        if (ireq_ready) begin
                            ireq_valid_q <= 1'b0;
                            redir_q      <= 1'b0;
                            state_q      <= (redirect_valid || redir_q) ? S_DRAIN : S_WAIT;
                        end else if (redirect_valid) begin
                            redir_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (iresp_valid) begin
                            state_q    <= S_HOLD;
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q;
                            if_instr_q <= iresp_data;
                        end else if (redirect_valid) begin
                            pend_q  <= redirect_pc;
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (redirect_valid) pend_q <= redirect_pc;   // latest wins
                    end
                    S_HOLD, S_RST: ;
                    default: state_q <= S_RST;
                endcase
            end
        end
    end

    assign ireq_valid = ireq_valid_q;
    assign ireq_addr  = pc_q;
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_instr   = if_instr_q;
    assign if_adel    = if_adel_q;

endmodule
